// File: rtl/bcd_scan_ctrl.sv
`default_nettype none
// bcd_scan_ctrl: time-multiplexed scan controller for an NDIG-digit BCD display.
// Optional leading-zero blanking is enabled by defining BCD_SCAN_LZ_BLANK_EN.
module bcd_scan_ctrl #(
  parameter int NDIG  = 4,
  parameter int DWELL = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                ld_valid,
  input  logic [4*NDIG-1:0]   ld_data,
  output logic                ld_ready,
  output logic [3:0]          dec_inp,
  output logic [NDIG-1:0]     dig_sel,
  output logic                frame_done,
  output logic                busy,
  output logic                err
);

  localparam int IW = (NDIG  > 1) ? $clog2(NDIG)  : 1;
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_BLANK = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     dcnt_q, dcnt_d;
  logic [4*NDIG-1:0] shadow_q, shadow_d;
  logic [4*NDIG-1:0] pbuf_q, pbuf_d;
  logic              pend_q, pend_d;
  logic              err_d;
  logic              fdone_d;
  logic              xfer;
  logic [3:0]        nib_d;
  logic              blank_d;

  function automatic logic has_bad(input logic [4*NDIG-1:0] v);
    logic b;
    b = 1'b0;
    for (int k = 0; k < NDIG; k++)
      if (v[4*k +: 4] > 4'd9) b = 1'b1;
    return b;
  endfunction

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    dcnt_d   = dcnt_q;
    shadow_d = shadow_q;
    pbuf_d   = pbuf_q;
    pend_d   = pend_q;
    err_d    = err;
    xfer     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d = S_SCAN;
          idx_d   = '0;
          dcnt_d  = '0;
          xfer    = 1'b1;
        end
      end
      S_SCAN: begin
        if (dcnt_q == CW'(DWELL - 1)) state_d = S_BLANK;
        else                          dcnt_d  = dcnt_q + 1'b1;
      end
      S_BLANK: begin
        idx_d  = '0;
        dcnt_d = '0;
        if (idx_q != IW'(NDIG - 1)) begin
          idx_d   = idx_q + 1'b1;
          state_d = S_SCAN;
        end else begin
          xfer    = 1'b1;
          state_d = en ? S_SCAN : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Transfer consumes the old buffer before a same-cycle load overwrites it.
    if (xfer && pend_q) begin
      shadow_d = pbuf_q;
      pend_d   = 1'b0;
      err_d    = has_bad(pbuf_q);
    end
    if (ld_valid && ld_ready) begin
      pbuf_d = ld_data;
      pend_d = 1'b1;
    end
    fdone_d = (state_d == S_BLANK) && (idx_d == IW'(NDIG - 1));
    nib_d   = shadow_d[4*int'(idx_d) +: 4];
    blank_d = (nib_d > 4'd9);
`ifdef BCD_SCAN_LZ_BLANK_EN
    if ((idx_d != '0) && ((shadow_d >> (4*int'(idx_d))) == '0)) blank_d = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      dcnt_q     <= '0;
      shadow_q   <= '0;
      pbuf_q     <= '0;
      pend_q     <= 1'b0;
      ld_ready   <= 1'b1;
      dec_inp    <= 4'd0;
      dig_sel    <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      dcnt_q     <= dcnt_d;
      shadow_q   <= shadow_d;
      pbuf_q     <= pbuf_d;
      pend_q     <= pend_d;
      ld_ready   <= ~pend_d;
      err        <= err_d;
      busy       <= (state_d != S_IDLE);
      frame_done <= fdone_d;
      dig_sel    <= ((state_d == S_SCAN) && !blank_d) ? (NDIG'(1) << idx_d) : '0;
      if (state_d == S_SCAN)      dec_inp <= nib_d;
      else if (state_d == S_IDLE) dec_inp <= 4'd0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_scan_ctrl.sv
`default_nettype none
// tb_bcd_scan_ctrl: table-driven frame checks plus handwritten reset/enable sequences.
module tb_bcd_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst, en, ld_valid;
  logic [15:0] ld_data;
  logic        ld_ready, frame_done, busy, err;
  logic [3:0]  dec_inp;
  logic [3:0]  dig_sel;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bcd_scan_ctrl #(.NDIG(4), .DWELL(4)) dut (
    .clk(clk), .rst(rst), .en(en), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .dec_inp(dec_inp), .dig_sel(dig_sel),
    .frame_done(frame_done), .busy(busy), .err(err)
  );

  // sel packs the expected strobe per slot: sel[k] = dig_sel during digit k's slot.
  typedef struct {
    logic [15:0]      val;
    logic [3:0][3:0]  sel;
    logic             err;
  } frame_t;

  frame_t ftab[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, " dig_sel"},    32'(dig_sel),    32'h0);
    chk({nm, " dec_inp"},    32'(dec_inp),    32'h0);
    chk({nm, " busy"},       32'(busy),       32'h0);
    chk({nm, " frame_done"}, 32'(frame_done), 32'h0);
    chk({nm, " ld_ready"},   32'(ld_ready),   32'h1);
  endtask

  // Entered positioned at frame sample 0; leaves positioned at sample n_smp.
  task automatic run_frame(input int f, input int load_at, input logic [15:0] load_val,
                           input int drop_en_at, input int n_smp);
    for (int i = 0; i < n_smp; i++) begin
      int s;
      int c;
      logic [3:0] exp_sel;
      logic [3:0] exp_dec;
      s = i / 5;
      c = i % 5;
      exp_sel = (c < 4) ? ftab[f].sel[s] : 4'h0;
      exp_dec = ftab[f].val[4*s +: 4];
      chk($sformatf("f%0d.%0d dig_sel", f, i),    32'(dig_sel),    32'(exp_sel));
      chk($sformatf("f%0d.%0d dec_inp", f, i),    32'(dec_inp),    32'(exp_dec));
      chk($sformatf("f%0d.%0d frame_done", f, i), 32'(frame_done), 32'(i == 19));
      chk($sformatf("f%0d.%0d busy", f, i),       32'(busy),       32'h1);
      chk($sformatf("f%0d.%0d err", f, i),        32'(err),        32'(ftab[f].err));
      chk($sformatf("f%0d.%0d ld_ready", f, i),   32'(ld_ready),
          32'((load_at >= 0 && i > load_at) ? 1'b0 : 1'b1));
      if (load_at >= 0 && i == load_at) begin
        ld_valid = 1'b1;
        ld_data  = load_val;
      end else if (load_at >= 0 && i == load_at + 1) begin
        ld_data  = 16'hFFFF;
      end else if (load_at >= 0 && i == load_at + 2) begin
        ld_valid = 1'b0;
      end
      if (i == drop_en_at) en = 1'b0;
      tick();
    end
  endtask

  initial begin
    ftab[0] = '{val: 16'h1234, sel: 16'h8421, err: 1'b0};
    ftab[1] = '{val: 16'h5678, sel: 16'h8421, err: 1'b0};
    ftab[2] = '{val: 16'h9A01, sel: 16'h8021, err: 1'b1};
`ifdef BCD_SCAN_LZ_BLANK_EN
    ftab[3] = '{val: 16'h0009, sel: 16'h0001, err: 1'b0};
    ftab[4] = '{val: 16'h0070, sel: 16'h0021, err: 1'b0};
    ftab[5] = '{val: 16'h0000, sel: 16'h0001, err: 1'b0};
`else
    ftab[3] = '{val: 16'h0009, sel: 16'h8421, err: 1'b0};
    ftab[4] = '{val: 16'h0070, sel: 16'h8421, err: 1'b0};
    ftab[5] = '{val: 16'h0000, sel: 16'h8421, err: 1'b0};
`endif
    ftab[6] = '{val: 16'h4321, sel: 16'h8421, err: 1'b0};

    rst = 1'b1; en = 1'b0; ld_valid = 1'b0; ld_data = 16'h0;
    tick();
    tick();
    rst = 1'b0;
    chk_idle("reset");
    chk("reset err", 32'(err), 32'h0);

    ld_valid = 1'b1; ld_data = 16'h1234;
    tick();
    chk("load ld_ready", 32'(ld_ready), 32'h0);
    chk("load busy",     32'(busy),     32'h0);
    ld_valid = 1'b0; en = 1'b1;
    tick();

    // Back-to-back frames, each loading the next value mid-frame.
    run_frame(0, 5, 16'h5678, -1, 20);
    run_frame(1, 5, 16'h9A01, -1, 20);
    run_frame(2, 5, 16'h0009, -1, 20);
    run_frame(3, 5, 16'h0070, -1, 20);
    run_frame(4, 5, 16'h0000, -1, 20);
    run_frame(5, -1, 16'h0, 6, 20);

    chk_idle("en-drop idle");
    tick();
    chk_idle("en-drop idle2");
    en = 1'b1;
    tick();
    run_frame(5, 5, 16'h4321, -1, 20);
    run_frame(6, -1, 16'h0, -1, 10);

    rst = 1'b1; en = 1'b0;
    tick();
    rst = 1'b0;
    chk_idle("mid rst");
    chk("mid rst err", 32'(err), 32'h0);
    tick();
    chk_idle("post rst");
    en = 1'b1;
    tick();
    run_frame(5, -1, 16'h0, -1, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
